fetch_redirect_unit: RTL and testbench

- PC-generation and fetch-sequencing stage that consumes the EX-stage branch decision (branch_taken) and feeds the IF/ID register.
- Owns the architectural fetch PC and issues single-outstanding valid/ready requests to instruction memory.
- Resolves branch, JAL and JALR redirects, including misaligned-target traps, and generates pipeline flushes.
- Buffers one fetched instruction while the hazard unit stalls.

---
 rtl/fetch_redirect_unit_pkg.sv | 8 +
 rtl/fetch_redirect_unit_if.sv | 11 +
 rtl/fetch_redirect_unit_redirect_target_calc.sv | 18 +
 rtl/fetch_redirect_unit.sv | 122 ++++++++++++
 tb/tb_fetch_redirect_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// fetch_pkg: shared fetch-stage types and constants (state enum, vectors, instruction width, PC step)
package fetch_pkg;
  localparam logic [63:0] RESET_VEC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [63:0] TRAP_VEC_DEF = 64'h0000_0000_8000_0100;
  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HELD} state_e;
endpackage

// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: imem valid/ready request + response bundle; master=fetch unit (req_valid/req_addr out), slave=memory (req_ready/rsp_valid/rsp_data out)
interface fetch_redirect_unit_if #(parameter int XLEN = 64);
  import fetch_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [XLEN-1:0] req_addr;
  logic rsp_valid;
  logic [INSTR_W-1:0] rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_redirect_unit_redirect_target_calc.sv
// redirect_target_calc: EX inputs (valid/type/taken/pc/imm/rs1) -> redirect_o, target_o (JALR bit0 cleared), misaligned_o
module redirect_target_calc #(parameter int XLEN = 64) (
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jal_i,
  input  logic            ex_is_jalr_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);
  assign redirect_o = ex_valid_i & ((ex_is_branch_i & branch_taken_i) | ex_is_jal_i | ex_is_jalr_i);
  assign target_o = ex_is_jalr_i ? ((ex_rs1_i + ex_imm_i) & ~{{(XLEN-1){1'b0}}, 1'b1}) : ex_pc_i + ex_imm_i;
  assign misaligned_o = target_o[1:0] != 2'b00;
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: fetch PC/imem sequencer; in: clk,rst_n,stall_i,ex_*; imem master port; out: if_valid/pc/instr, flush_o, misalign_o/addr, redirect_cnt_o
module fetch_redirect_unit import fetch_pkg::*; #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_branch_i,
  input  logic                  ex_is_jal_i,
  input  logic                  ex_is_jalr_i,
  input  logic                  branch_taken_i,
  input  logic [XLEN-1:0]       ex_pc_i,
  input  logic [XLEN-1:0]       ex_imm_i,
  input  logic [XLEN-1:0]       ex_rs1_i,
  fetch_redirect_unit_if.master imem,
  output logic                  if_valid_o,
  output logic [XLEN-1:0]       if_pc_o,
  output logic [INSTR_W-1:0]    if_instr_o,
  output logic                  flush_o,
  output logic                  misalign_o,
  output logic [XLEN-1:0]       misalign_addr_o,
  output logic [CNT_W-1:0]      redirect_cnt_o
);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, target, eff;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q;
  logic squash_q, squash_d, pend_valid_q, pend_valid_d, redirect, misaligned;
  redirect_target_calc #(.XLEN(XLEN)) u_calc (
    .ex_valid_i(ex_valid_i),
    .ex_is_branch_i(ex_is_branch_i),
    .ex_is_jal_i(ex_is_jal_i),
    .ex_is_jalr_i(ex_is_jalr_i),
    .branch_taken_i(branch_taken_i),
    .ex_pc_i(ex_pc_i),
    .ex_imm_i(ex_imm_i),
    .ex_rs1_i(ex_rs1_i),
    .redirect_o(redirect),
    .target_o(target),
    .misaligned_o(misaligned)
  );
  assign eff = misaligned ? TRAP_VEC : target;
  assign flush_o = redirect;
  assign misalign_o = redirect & misaligned;
  assign misalign_addr_o = misalign_o ? target : '0;
  assign redirect_cnt_o = cnt_q;
  assign imem.req_valid = rst_n & (state_q == S_REQ);
  assign imem.req_addr = pc_q;
  assign if_pc_o = if_valid_o ? pc_q : '0;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    squash_d = squash_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d = pend_pc_q;
    hold_d = hold_q;
    if_valid_o = 1'b0;
    if_instr_o = '0;
    case (state_q)
      S_REQ:
        if (imem.req_ready) begin
          // the request on the bus goes out regardless; a redirect or parked target only moves the PC behind it
          state_d = S_WAIT;
          pc_d = redirect ? eff : (pend_valid_q ? pend_pc_q : pc_q);
          pend_valid_d = 1'b0;
          squash_d = squash_q | redirect;
        end else if (redirect) begin
          pend_valid_d = 1'b1;
          pend_pc_d = eff;
          squash_d = 1'b1;
        end
      S_WAIT:
        if (redirect) begin
          // a response arriving alongside the redirect is simply dropped, nothing stays outstanding
          pc_d = eff;
          squash_d = ~imem.rsp_valid;
          state_d = imem.rsp_valid ? S_REQ : S_WAIT;
        end else if (imem.rsp_valid) begin
          squash_d = 1'b0;
          state_d = (squash_q | ~stall_i) ? S_REQ : S_HELD;
          hold_d = (!squash_q && stall_i) ? imem.rsp_data : hold_q;
          if_valid_o = ~squash_q & ~stall_i;
          if_instr_o = if_valid_o ? imem.rsp_data : '0;
          pc_d = if_valid_o ? pc_q + XLEN'(PC_INC) : pc_q;
        end
      S_HELD:
        if (redirect) begin
          pc_d = eff;
          state_d = S_REQ;
        end else if (!stall_i) begin
          if_valid_o = 1'b1;
          if_instr_o = hold_q;
          pc_d = pc_q + XLEN'(PC_INC);
          state_d = S_REQ;
        end
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q <= RESET_VEC;
      squash_q <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q <= '0;
      hold_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      squash_q <= squash_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q <= pend_pc_d;
      hold_q <= hold_d;
      cnt_q <= (redirect && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
  end
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: random + directed stimulus against an instruction-stream reference model with a memory responder
module tb_fetch_redirect_unit;
  import fetch_pkg::*;
  localparam logic [63:0] RV = 64'h8000_0000;
  localparam logic [63:0] TV = 64'h8000_0100;
  logic clk = 0, rst_n = 0, stall = 0;
  logic ex_valid = 0, ex_br = 0, ex_jal = 0, ex_jalr = 0, taken = 0;
  logic [63:0] ex_pc = 0, ex_imm = 0, ex_rs1 = 0;
  logic if_valid, flush, misalign;
  logic [63:0] if_pc, mis_addr;
  logic [31:0] if_instr;
  logic [15:0] cnt;
  int checks = 0, failures = 0;
  int ready_pct = 100, lat_min = 1, lat_max = 1;
  bit busy = 0;
  int wait_cnt = 0;
  logic [63:0] raddr = 0;
  logic [63:0] stream_pc = RV, prev_addr = 0;
  logic [15:0] m_cnt = 0;
  bit prev_hold = 0;
  int idle = 0;
  fetch_redirect_unit_if #(.XLEN(64)) imem();
  fetch_redirect_unit #(.XLEN(64), .RESET_VEC(RV), .TRAP_VEC(TV), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .ex_valid_i(ex_valid), .ex_is_branch_i(ex_br), .ex_is_jal_i(ex_jal), .ex_is_jalr_i(ex_jalr),
    .branch_taken_i(taken), .ex_pc_i(ex_pc), .ex_imm_i(ex_imm), .ex_rs1_i(ex_rs1),
    .imem(imem),
    .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr),
    .flush_o(flush), .misalign_o(misalign), .misalign_addr_o(mis_addr), .redirect_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(logic [63:0] a);
    return (a == TV) ? 32'h0000_0013 : {a[31:2] ^ 30'h2AAA_5555, 2'b11};
  endfunction
  task automatic check(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    imem.rsp_valid = 1'b0;
    if (rst_n && busy) begin
      if (wait_cnt == 0) begin
        imem.rsp_valid = 1'b1;
        imem.rsp_data = mem_word(raddr);
      end else wait_cnt--;
    end
  end
  always @(negedge clk) begin
    logic [63:0] raw;
    logic rd, mis;
    if (!rst_n) begin
      busy = 0;
      stream_pc = RV;
      m_cnt = 0;
      idle = 0;
      prev_hold = 0;
    end else begin
      raw = ex_jalr ? ((ex_rs1 + ex_imm) & ~64'd1) : ex_pc + ex_imm;
      rd = ex_valid && ((ex_br && taken) || ex_jal || ex_jalr);
      mis = raw[1:0] != 2'b00;
      check("flush", 64'(flush), 64'(rd));
      check("misalign", 64'(misalign), 64'(rd && mis));
      if (rd && mis) check("misalign_addr", mis_addr, raw);
      check("redirect_cnt", 64'(cnt), 64'(m_cnt));
      if (if_valid) begin
        check("deliver_when_stall_or_redirect", 64'({stall, rd}), 64'd0);
        check("if_pc", if_pc, stream_pc);
        check("if_instr", 64'(if_instr), 64'(mem_word(if_pc)));
      end
      if (imem.req_valid) check("single_outstanding", 64'(busy), 64'd0);
      if (prev_hold) begin
        check("req_valid_held", 64'(imem.req_valid), 64'd1);
        check("req_addr_stable", imem.req_addr, prev_addr);
      end
      prev_hold = imem.req_valid && !imem.req_ready;
      prev_addr = imem.req_addr;
      if (if_valid || rd) idle = 0;
      else if (!stall) idle++;
      if (idle > 60) begin
        check("liveness_idle_cycles", 64'(idle), 64'd0);
        idle = 0;
      end
      if (imem.rsp_valid) busy = 0;
      if (imem.req_valid && imem.req_ready) begin
        busy = 1;
        raddr = imem.req_addr;
        wait_cnt = $urandom_range(lat_max, lat_min) - 1;
      end
      if (rd) begin
        stream_pc = mis ? TV : raw;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end else if (if_valid) stream_pc += 64'd4;
    end
  end
  task automatic next();
    @(posedge clk);
    #1;
    imem.req_ready = ($urandom_range(99) < ready_pct);
  endtask
  task automatic clear_ex();
    ex_valid = 0; ex_br = 0; ex_jal = 0; ex_jalr = 0; taken = 0;
  endtask
  task automatic wait_accept(output logic [63:0] a);
    int n = 0;
    do begin next(); @(negedge clk); n++; end while (!(imem.req_valid && imem.req_ready) && n < 200);
    check("accept_in_time", 64'(n < 200), 64'd1);
    a = imem.req_addr;
  endtask
  task automatic wait_if(output logic [63:0] pc, output int n);
    n = 0;
    do begin next(); @(negedge clk); n++; end while (!if_valid && n < 200);
    check("deliver_in_time", 64'(n < 200), 64'd1);
    pc = if_pc;
  endtask
  initial begin
    logic [63:0] a, pc;
    logic [11:0] v;
    int n;
    imem.req_ready = 1; imem.rsp_valid = 0; imem.rsp_data = 0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", 64'(imem.req_valid), 64'd0);
    check("rst_req_addr", imem.req_addr, RV);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", if_pc, 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    next();
    rst_n = 1;
    @(negedge clk);
    check("first_req_valid", 64'(imem.req_valid), 64'd1);
    check("first_req_addr", imem.req_addr, RV);
    wait_if(pc, n);
    check("seq_pc0", pc, 64'h8000_0000);
    wait_if(pc, n);
    check("seq_pc1", pc, 64'h8000_0004);
    check("seq_gap1", 64'(n), 64'd2);
    wait_if(pc, n);
    check("seq_pc2", pc, 64'h8000_0008);
    check("seq_gap2", 64'(n), 64'd2);
    lat_min = 3; lat_max = 3;
    wait_accept(a);
    next();
    ex_valid = 1; ex_br = 1; taken = 1; ex_pc = 64'h8000_0010; ex_imm = 64'h20;
    @(negedge clk);
    check("beq_flush", 64'(flush), 64'd1);
    next();
    clear_ex();
    @(negedge clk);
    check("beq_cnt", 64'(cnt), 64'd1);
    wait_accept(a);
    check("beq_next_req", a, 64'h8000_0030);
    wait_if(pc, n);
    check("beq_next_pc", pc, 64'h8000_0030);
    lat_min = 1; lat_max = 1; ready_pct = 0;
    next();
    ex_valid = 1; ex_jal = 1; ex_pc = 64'h8000_0200; ex_imm = 64'h40;
    @(negedge clk);
    check("nr_flush", 64'(flush), 64'd1);
    check("nr_addr0", imem.req_addr, 64'h8000_0034);
    for (int i = 0; i < 2; i++) begin
      next();
      clear_ex();
      @(negedge clk);
      check("nr_addr_hold", imem.req_addr, 64'h8000_0034);
    end
    ready_pct = 100;
    next();
    @(negedge clk);
    check("nr_old_accepted", imem.req_addr, 64'h8000_0034);
    wait_accept(a);
    check("nr_target_req", a, 64'h8000_0240);
    wait_if(pc, n);
    check("nr_target_pc", pc, 64'h8000_0240);
    lat_min = 3; lat_max = 3;
    wait_accept(a);
    next();
    ex_valid = 1; ex_jalr = 1; ex_rs1 = 64'h8000_1003; ex_imm = 0;
    @(negedge clk);
    check("jalr_misalign", 64'(misalign), 64'd1);
    check("jalr_misalign_addr", mis_addr, 64'h8000_1002);
    next();
    clear_ex();
    stall = 1;
    wait_accept(a);
    check("trap_req", a, 64'h8000_0100);
    for (int i = 0; i < 6; i++) begin
      next();
      @(negedge clk);
      check("held_no_valid", 64'(if_valid), 64'd0);
    end
    check("held_no_req", 64'(imem.req_valid), 64'd0);
    next();
    stall = 0;
    @(negedge clk);
    check("held_release_valid", 64'(if_valid), 64'd1);
    check("held_release_pc", if_pc, 64'h8000_0100);
    check("held_release_instr", 64'(if_instr), 64'h13);
    ready_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      next();
      stall = ($urandom_range(99) < 25);
      clear_ex();
      if ($urandom_range(99) < 15) begin
        ex_valid = 1;
        case ($urandom_range(2))
          0: begin ex_br = 1; taken = $urandom_range(1) == 1; end
          1: ex_jal = 1;
          default: ex_jalr = 1;
        endcase
        v = 12'($urandom_range(4095));
        ex_imm = {{52{v[11]}}, v};
        if ($urandom_range(9) != 0) ex_imm[1:0] = 2'b00;
        ex_pc = RV + 64'($urandom_range(255) * 4);
        ex_rs1 = RV + 64'($urandom_range(4095));
      end
    end
    stall = 0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 65539; i++) begin
      next();
      ex_valid = 1; ex_jal = 1; ex_br = 0; ex_jalr = 0; ex_pc = RV; ex_imm = 64'h40;
    end
    next();
    clear_ex();
    @(negedge clk);
    check("cnt_saturated", 64'(cnt), 64'hFFFF);
    lat_min = 3; lat_max = 3;
    wait_accept(a);
    next();
    #2;
    rst_n = 0;
    #1;
    check("async_rst_req_valid", 64'(imem.req_valid), 64'd0);
    check("async_rst_req_addr", imem.req_addr, RV);
    check("async_rst_cnt", 64'(cnt), 64'd0);
    check("async_rst_if_valid", 64'(if_valid), 64'd0);
    repeat (2) @(negedge clk);
    next();
    rst_n = 1;
    @(negedge clk);
    check("post_rst_req", imem.req_addr, RV);
    check("post_rst_req_valid", 64'(imem.req_valid), 64'd1);
    wait_if(pc, n);
    check("post_rst_pc", pc, RV);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
